button_conditioner: RTL
=======================

# button_conditioner

Input-conditioning stage between the raw board push-buttons and the game top level. Synchronizes each raw active-low button to `clk` and debounces it. Produces per button a clean level, a one-cycle press pulse and a one-cycle release pulse. The game FSM, ship movement and ammunition logic consume these signals instead of the raw pins, so a bounce can no longer fire two shots or skip a pre-game/restart state.

## Interface
- `N_BUTTONS`, 4 — number of independent channels; bit 0 = A … bit 3 = D.
- `DEBOUNCE_CYCLES`, 1000000 — consecutive stable cycles required to accept a change (20 ms at 50 MHz); must be ≥ 2.
- `REPEAT_DELAY`, 25000000 — cycles of continuous hold before the first auto-repeat pulse.
- `REPEAT_PERIOD`, 5000000 — cycles between later auto-repeat pulses.

Ports:
- `clk` in 1 — system clock (50 MHz).
- `reset` in 1 — asynchronous, active-low reset.
- `btn_raw` in N_BUTTONS — raw pins, active-low (0 = pressed), asynchronous to `clk`.
- `btn_level` out N_BUTTONS — debounced level, active-low, same polarity as the raw pins.
- `btn_press` out N_BUTTONS — one-cycle high pulse per accepted press, plus auto-repeat pulses.
- `btn_release` out N_BUTTONS — one-cycle high pulse per accepted release.

## Operation
- Each channel is independent and identical. There is no cross-channel interaction.
- Synchronizer: 2 flops per channel, reset to 1 (released).
- Per-channel FSM with four states:
  - IDLE (level=1): when the sync output is 0, clear the counter and go to PRESS_WAIT.
  - PRESS_WAIT: if the sync output returns to 1, go to IDLE (bounce rejected). Otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES−1, go to HELD, drive level=0 and pulse `btn_press`.
  - HELD (level=0): when the sync output is 1, clear the counter and go to RELEASE_WAIT.
  - RELEASE_WAIT: if the sync output returns to 0, go to HELD. There is no press pulse and the repeat timer keeps its value. When the counter reaches DEBOUNCE_CYCLES−1, go to IDLE, drive level=1 and pulse `btn_release`.
- Debounce counter width is $clog2(DEBOUNCE_CYCLES). The counter saturates and never wraps.
- A press and a release pulse never occur on the same channel in the same cycle.
- Different channels may pulse in the same cycle.
- Reset asserted mid-operation: every channel goes to IDLE immediately (asynchronously), the counters clear, and no release pulse is emitted.

## Timing
- Reset values: `btn_level` = all 1s, `btn_press` = 0, `btn_release` = 0.
- Latency: a raw edge held clean reaches `btn_level` and the pulse after 2 (sync) + DEBOUNCE_CYCLES cycles.
- Pulses are exactly 1 cycle wide, registered, and coincident with the `btn_level` transition.
- Input glitch rejection: any excursion shorter than DEBOUNCE_CYCLES cycles (after sync) produces no output change.

## Configuration
- `BUTTON_AUTOREPEAT_EN` defined:
  - In HELD, a repeat counter (width $clog2(REPEAT_DELAY)) runs.
  - An extra `btn_press` pulse fires REPEAT_DELAY cycles after the accepted press.
  - Further pulses fire every REPEAT_PERIOD cycles while the button stays in HELD/RELEASE_WAIT.
  - The repeat counter clears on entry to IDLE.
- Undefined: exactly one `btn_press` per accepted press. No repeat counter logic is synthesized.

## Structure
- Shared package `button_pkg`:
  - Channel state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Default cycle constants for 50 MHz.
  - Index constants BTN_A…BTN_D.
- Sub-module `button_channel`: synchronizer, FSM, debounce and repeat counters for a single button. The top generates N_BUTTONS instances.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=6.

- **Reset:** hold `reset`=0 with `btn_raw`=4'b0000 → `btn_level`=4'hF, no pulses; after release, `btn_press`[3:0] pulse once 10 cycles later.
- **Bounce rejection:** toggle `btn_raw`[0] 0/1 every 3 cycles for 30 cycles, then hold 1 → `btn_level`[0] stays 1, zero pulses.
- **Clean press/release:** `btn_raw`[3] 1→0 held 20 cycles, then 0→1:
  - `btn_press`[3] pulse at +10 with level→0.
  - `btn_release`[3] pulse 10 cycles after the rising edge.
  - Each pulse exactly 1 cycle.
- **Release bounce:** while HELD, `btn_raw`[1]=1 for 4 cycles, then back to 0 → no release pulse, no second press pulse.
- **Simultaneous channels:** `btn_raw` 4'hF→4'h0 on the same cycle → all four press pulses in the same cycle.
- **Mid-debounce reset and auto-repeat:**
  - Assert `reset` 5 cycles into PRESS_WAIT → no pulse.
  - With `BUTTON_AUTOREPEAT_EN`, hold 50 cycles → press pulses at +10, +30, +36, +42, +48.

Source files
------------

// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioning stage: channel state
// encoding, default 50 MHz timing constants and button index names.
package button_pkg;

  // Per-channel debounce state.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  // Defaults for a 50 MHz system clock.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;   // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 25000000;  // 500 ms
  localparam int unsigned DEF_REPEAT_PERIOD   = 5000000;   // 100 ms

  // Bit positions of the board buttons in the btn_* vectors.
  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;
  localparam int BTN_D = 3;

  // True in the states where the debounced button reads as pressed.
  function automatic logic is_down(input btn_state_e s);
    return (s == HELD) || (s == RELEASE_WAIT);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM with saturating
// counter, registered level/press/release outputs and (with
// BUTTON_AUTOREPEAT_EN defined) an auto-repeat timer that adds press pulses
// while the button stays down.
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | debounced released, waiting for sync input to go low
// PRESS_WAIT   | input low, counting stable cycles before accepting press
// HELD         | debounced pressed, waiting for sync input to go high
// RELEASE_WAIT | input high, counting stable cycles before accepting release
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,  // >= 2
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD     // <= REPEAT_DELAY
) (
  input  logic clk,
  input  logic reset,     // async, active-low
  input  logic raw_b,     // raw pin, active-low
  output logic level_b,   // debounced level, active-low
  output logic press,
  output logic rel
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES);
  // The wait states exit on the edge where the count would reach
  // DEBOUNCE_CYCLES-1; together with the detecting cycle in IDLE/HELD this
  // gives exactly DEBOUNCE_CYCLES consecutive stable samples.
  localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_CYCLES - 2);
  localparam logic [DCW-1:0] DB_MAX  = '1;

  logic [1:0]     sync_q, sync_d;
  logic           sync_in;
  btn_state_e     state_q, state_d;
  logic [DCW-1:0] cnt_q, cnt_d;
  logic           db_done;
  logic           level_q, level_d;
  logic           press_q, press_d;
  logic           rel_q, rel_d;
  logic           accept_press, accept_rel;
  logic           rpt_fire;

  assign sync_in = sync_q[1];
  assign db_done = (cnt_q == DB_LAST);

  // Synchronizer shift: raw pin enters at bit 0, FSM reads bit 1.
  always_comb begin
    sync_d = {sync_q[0], raw_b};
  end

  // State register, synchronizer, debounce counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!sync_in) state_d = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (sync_in)      state_d = IDLE;
        else if (db_done) state_d = HELD;
      end
      HELD: begin
        if (sync_in) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (!sync_in)     state_d = HELD;
        else if (db_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Debounce counter: held at zero in the settled states so every wait
  // starts from a clean count, saturating while waiting.
  always_comb begin
    cnt_d = cnt_q;
    case (state_q)
      PRESS_WAIT, RELEASE_WAIT: begin
        if (cnt_q != DB_MAX) cnt_d = cnt_q + DCW'(1);
      end
      default: cnt_d = '0;
    endcase
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RCW = $clog2(REPEAT_DELAY);
  localparam logic [RCW-1:0] RPT_LAST   = RCW'(REPEAT_DELAY - 1);
  // Reloading to DELAY-PERIOD makes later pulses PERIOD cycles apart while
  // reusing the single terminal-count compare.
  localparam logic [RCW-1:0] RPT_RELOAD = RCW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [RCW-1:0] rpt_q, rpt_d;

  // Repeat timer: starts at zero on the accepted press, runs while down,
  // suppressed on the cycle a release is accepted.
  always_comb begin
    rpt_d    = rpt_q;
    rpt_fire = 1'b0;
    if (!is_down(state_q) || (state_d == IDLE)) begin
      rpt_d = '0;
    end else if (rpt_q == RPT_LAST) begin
      rpt_fire = 1'b1;
      rpt_d    = RPT_RELOAD;
    end else begin
      rpt_d = rpt_q + RCW'(1);
    end
  end

  // Repeat timer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rpt_q <= '0;
    else        rpt_q <= rpt_d;
  end
`else
  // Without auto-repeat only accepted presses pulse.
  always_comb begin
    rpt_fire = 1'b0;
  end
`endif

  // Output logic: pulses and level follow the transition being taken, so
  // they register on the same edge as the state change.
  always_comb begin
    accept_press = (state_q == PRESS_WAIT)   && (state_d == HELD);
    accept_rel   = (state_q == RELEASE_WAIT) && (state_d == IDLE);
    level_d      = !is_down(state_d);
    press_d      = accept_press | rpt_fire;
    rel_d        = accept_rel;
  end

  assign level_b = level_q;
  assign press   = press_q;
  assign rel     = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Input conditioning for the board push-buttons: one independent
// synchronize/debounce channel per button feeding the game logic with clean
// levels and single-cycle press/release pulses.
// Optional feature macro: BUTTON_AUTOREPEAT_EN (auto-repeat press pulses).
module button_conditioner
  import button_pkg::*;
#(
  parameter int          N_BUTTONS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                 clk,
  input  logic                 reset,        // async, active-low
  input  logic [N_BUTTONS-1:0] btn_raw,      // active-low pins
  output logic [N_BUTTONS-1:0] btn_level,    // active-low debounced
  output logic [N_BUTTONS-1:0] btn_press,
  output logic [N_BUTTONS-1:0] btn_release
);

  // One identical channel per button; no cross-channel interaction.
  for (genvar g = 0; g < N_BUTTONS; g++) begin : g_chan
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .raw_b   (btn_raw[g]),
      .level_b (btn_level[g]),
      .press   (btn_press[g]),
      .rel     (btn_release[g])
    );
  end

endmodule
